// File: rtl/t_ff.sv
// t_ff: bank of WIDTH independent toggle flip-flops with complementary outputs.
//   clk   - rising-edge clock, the only timing reference
//   t     - per-bit toggle request, sampled on the rising edge of clk
//   reset - synchronous active-high reset; loads RESET_VALUE and overrides t
//   q     - registered toggle state
//   qbar  - registered bitwise complement of q, updated in lockstep with q
module t_ff #(
    parameter int unsigned           WIDTH       = 1,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] t,
    input  logic             reset,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] qbar_q;

    // Next state: bits with t set invert, all other bits hold.
    always_comb begin
        q_d = q_q;
        q_d = q_q ^ t;
    end

    // State registers. qbar gets its own flop so both outputs leave flops on
    // the same edge and can never be caught equal after the first reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= RESET_VALUE;
            qbar_q <= ~RESET_VALUE;
        end else begin
            q_q    <= q_d;
            qbar_q <= ~q_d;
        end
    end

    assign q    = q_q;
    assign qbar = qbar_q;

endmodule

// File: tb/tb_t_ff.sv
// tb_t_ff: randomized self-checking bench for t_ff. Drives a WIDTH=4 bank with a
// non-zero reset value and a default WIDTH=1 instance from the same reset.
// The reference counts toggle requests per bit since the last reset; the
// expected state is the reset value XOR the parity of that count.
module tb_t_ff;

    localparam int unsigned W  = 4;
    localparam logic [W-1:0] RV = 4'b1010;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] t4;
    logic [W-1:0] q4, qb4;
    logic         t1;
    logic         q1, qb1;

    int vectors     = 0;
    int miscompares = 0;

    int toggles [W];
    bit seen_reset = 1'b0;

    logic [W-1:0] trace_q [3][3];

    t_ff #(.WIDTH(W), .RESET_VALUE(RV)) u_dut4 (
        .clk   (clk),
        .t     (t4),
        .reset (reset),
        .q     (q4),
        .qbar  (qb4)
    );

    t_ff u_dut1 (
        .clk   (clk),
        .t     (t1),
        .reset (reset),
        .q     (q1),
        .qbar  (qb1)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %b, expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_q4();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = RV[i] ^ ((toggles[i] % 2) == 1);
        return v;
    endfunction

    function automatic logic exp_q1();
        // The WIDTH=1 instance sees t4[0] and resets to 0.
        return (toggles[0] % 2) == 1;
    endfunction

    // Apply inputs mid-cycle, confirm outputs have not moved before the edge,
    // take one rising edge, update the reference, then check the new state.
    task automatic step(input logic rst, input logic [W-1:0] tv);
        reset = rst;
        t4    = tv;
        t1    = tv[0];
        #2;
        if (seen_reset) begin
            check("pre_edge_q4", q4, exp_q4());
            check("pre_edge_q1", {3'b000, q1}, {3'b000, exp_q1()});
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < W; i++) toggles[i] = 0;
            seen_reset = 1'b1;
        end else begin
            for (int i = 0; i < W; i++) toggles[i] += int'(tv[i]);
        end
        #1;
        check("q4",    q4,  exp_q4());
        check("qbar4", qb4, ~exp_q4());
        check("q_ne_qbar4", q4 ^ qb4, 4'hF);
        check("q1",    {3'b000, q1},  {3'b000, exp_q1()});
        check("qbar1", {3'b000, qb1}, {3'b000, ~exp_q1()});
    endtask

    initial begin
        reset = 1'b1;
        t4    = '0;
        t1    = 1'b0;
        for (int i = 0; i < W; i++) toggles[i] = 0;
        @(posedge clk);
        #1;

        // Reset held two edges with t low, then with t high.
        step(1'b1, 4'h0);
        check("reset_const_q4", q4, RV);
        check("reset_const_q1", {3'b000, q1}, 4'b0000);
        step(1'b1, 4'hF);

        // Hold for three edges.
        repeat (3) step(1'b0, 4'h0);

        // Toggle four edges: divide-by-two.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 4'hF);
            check("toggle_seq_q1", {3'b000, q1}, (k % 2 == 0) ? 4'b0001 : 4'b0000);
        end

        // Reset priority while toggling, then release with t high.
        step(1'b0, 4'hF);
        step(1'b1, 4'hF);
        check("rst_prio_q4", q4, RV);
        step(1'b1, 4'hF);
        step(1'b0, 4'hF);
        check("rst_release_q4", q4, ~RV);
        check("rst_release_q1", {3'b000, q1}, 4'b0001);

        // Mid-cycle t pulse that is gone before the edge.
        t4 = 4'hF;
        t1 = 1'b1;
        #3;
        t4 = 4'h0;
        t1 = 1'b0;
        step(1'b0, 4'h0);

        // Repeated reset/release/toggle sequence must give identical traces.
        for (int it = 0; it < 3; it++) begin
            repeat (3) step(1'b1, 4'h0);
            step(1'b0, 4'h0);
            trace_q[it][0] = q4;
            step(1'b0, 4'hF);
            trace_q[it][1] = q4;
            step(1'b0, 4'hF);
            trace_q[it][2] = q4;
            if (it > 0)
                for (int s = 0; s < 3; s++) check("repeat_trace", trace_q[it][s], trace_q[0][s]);
        end

        // Partial toggle pattern from the reset value.
        step(1'b1, 4'h0);
        step(1'b0, 4'b0011);
        check("pattern_q4",    q4,  4'b1001);
        check("pattern_qbar4", qb4, 4'b0110);

        // Randomized run with occasional reset.
        repeat (300) begin
            step(($urandom_range(0, 19) == 0), W'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
